// File: rtl/sqrt_lut_interp.sv
// Piecewise-linear square-root evaluator: one coefficient ROM read per operand,
// then out_y = B + ((K * frac) >> FRAC_W), clipped to 12'hFFF, returned over valid/ready.
module sqrt_lut_interp #(
  parameter int ROM_LAT = 1,
  parameter int FRAC_W  = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_x,
  output logic        rom_en,
  output logic [9:0]  rom_addr,
  input  logic [19:0] rom_para,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_y,
  output logic        out_sat
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_CALC = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;

  localparam logic [1:0] CNT_INIT = 2'(ROM_LAT - 1);

  logic [2:0]          state_q, state_d;
  logic [9:0]          addr_q, addr_d;
  logic [FRAC_W-1:0]   frac_q, frac_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [19:0]         coef_q, coef_d;
  logic                out_valid_q, out_valid_d;
  logic [11:0]         out_y_q, out_y_d;
  logic                out_sat_q, out_sat_d;

  logic [7+FRAC_W:0]   prod;
  logic [7:0]          inc;
  logic [12:0]         sum;

  always_comb begin
    prod = coef_q[7:0] * frac_q;
    inc  = prod[7+FRAC_W:FRAC_W];
    sum  = {1'b0, coef_q[19:8]} + {5'b0, inc};
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    frac_d      = frac_q;
    cnt_d       = cnt_q;
    coef_d      = coef_q;
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    out_sat_d   = out_sat_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          addr_d  = in_x[15:FRAC_W];
          frac_d  = in_x[FRAC_W-1:0];
          state_d = S_RD;
        end
      end
      S_RD: begin
        cnt_d   = CNT_INIT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          coef_d  = rom_para;
          state_d = S_CALC;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_CALC: begin
        // sum[12] set means the 13-bit sum exceeds the 12-bit Q8.4 range
        out_y_d     = sum[12] ? 12'hFFF : sum[11:0];
        out_sat_d   = sum[12];
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      frac_q      <= '0;
      cnt_q       <= '0;
      coef_q      <= '0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      frac_q      <= frac_d;
      cnt_q       <= cnt_d;
      coef_q      <= coef_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      out_sat_q   <= out_sat_d;
    end
  end

  // in_ready is gated by rst_n so it reads 0 for the whole reset pulse
  assign in_ready  = rst_n && (state_q == S_IDLE);
  assign rom_en    = (state_q == S_RD);
  assign rom_addr  = addr_q;
  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_sat   = out_sat_q;

endmodule

// File: doc/sqrt_lut_interp.md
Name: sqrt_lut_interp

Overview:
- Piecewise-linear square-root evaluator for the task_3 sqrt datapath. It sits directly upstream and downstream of the coefficient ROM wrapper.
- Splits a 16-bit unsigned operand into a 10-bit segment index and a 6-bit fraction. Issues one ROM read per operand, consumes the 20-bit coefficient word, and returns a Q8.4 square-root estimate over a valid/ready handshake.
- Handles one transaction at a time.

Parameters:
- ROM_LAT, 1, cycles from rom_en being sampled high to rom_para valid. Legal range 1..4.
- FRAC_W, 6, fraction bits of the operand. Fixed by the 10-bit ROM address; not to be overridden.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand valid
- in_ready  out  1  block can accept an operand
- in_x  in  16  unsigned operand
- rom_en  out  1  ROM read enable; drives wrapper val_i
- rom_addr  out  10  ROM address; drives wrapper read_addr
- rom_para  in  20  ROM data; [19:8] = base B (unsigned Q8.4), [7:0] = slope K (unsigned)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_y  out  12  sqrt estimate, unsigned Q8.4
- out_sat  out  1  result was clipped to 12'hFFF

Behaviour:
- Reset (async assert, sync release): state = IDLE.
  - in_ready = 1 after release; it is 0 while rst_n is low.
  - rom_en, rom_addr, out_valid, out_y, out_sat, wait counter and internal registers = 0.
- States:
  - IDLE: in_ready = 1. On in_valid & in_ready, register addr = in_x[15:6] and frac = in_x[5:0], then go to RD.
  - RD: one cycle. rom_en = 1, rom_addr = addr. Load wait counter with ROM_LAT-1, then go to WAIT.
  - WAIT: rom_en = 0. rom_addr holds its value. Counter decrements each cycle. When the counter is 0, capture rom_para into the coef register and go to CALC.
  - CALC: compute the result, register out_y/out_sat, set out_valid = 1, go to OUT.
  - OUT: out_valid = 1. out_y and out_sat are held stable. On out_ready, clear out_valid at the next edge and go to IDLE.
- Arithmetic:
  - prod = K * frac (14 bits).
  - inc = prod >> 6 (8 bits, truncate).
  - sum = {1'b0, B} + inc (13 bits).
  - If sum > 12'hFFF: out_y = 12'hFFF, out_sat = 1. Otherwise out_y = sum[11:0], out_sat = 0.
- Latency, with acceptance at cycle T:
  - rom_en high in cycle T+1.
  - rom_para sampled at the edge ending cycle T+1+ROM_LAT.
  - out_valid high from cycle T+3+ROM_LAT; this is 4 cycles for ROM_LAT = 1.
- Throughput: one operand per ROM_LAT+4 cycles when out_ready is held high. in_ready is low in every state except IDLE.
- in_valid outside IDLE is ignored. in_x is not sampled again until the next IDLE acceptance.
- rom_en is never high for more than one cycle per transaction.
- out_valid stays high, with stable data, until out_ready is seen. out_ready while out_valid = 0 has no effect.
- Reset mid-transaction, in any state: all outputs and registers clear immediately. No ROM read is reissued, and no stale result appears after release.
- frac = 0: out_y = B exactly.
- addr wrap is not possible: 10 bits span all 1024 segments.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with in_valid = 1 -> in_ready = 0, rom_en = 0, out_valid = 0, out_y = 0. After release -> in_ready = 1, and the first acceptance occurs on the first edge after release.
- Zero fraction: in_x = 16'h0000, ROM[0] = 20'h000_10, ROM_LAT = 1 -> rom_addr = 0, rom_en pulses 1 cycle, out_y = 12'h000, out_sat = 0, out_valid 4 cycles after accept.
- Interpolation: in_x = 16'h1234, ROM[10'h048] = 20'h448_20 -> rom_addr = 10'h048, frac = 52, inc = 26, out_y = 12'h462, out_sat = 0.
- Saturation: in_x = 16'hFFFF, ROM[10'h3FF] = 20'hFF0_FF -> inc = 251, sum = 13'h10EB, out_y = 12'hFFF, out_sat = 1.
- Backpressure and latency: ROM_LAT = 3, out_ready low for 5 cycles -> out_valid first high 6 cycles after accept; out_y/out_valid stable while out_ready is low; in_ready = 0 throughout; exactly one rom_en pulse; after the out_ready handshake, in_ready = 1 the next cycle.
- Reset mid-op: assert rst_n low during WAIT, release, then send in_x = 16'h0040 with ROM[1] = 20'h010_00 -> no output from the aborted transaction; out_y = 12'h010 for the new operand.
